round_controller: RTL and testbench
===================================

// Module: round_controller
// PURPOSE
//  Match sequencer for the two-player fighter. Runs countdown, fight, round-end and match-end phases.
//  Gates player commands into one action per game tick and resets the LeftPlayer/RightPlayer instances
//  between rounds. Detects KO or timeout from the player health outputs, then keeps the round score and
//  declares the match winner.
// PARAMETERS
//  ROUND_TIME       8  game ticks per round; timer width TW = $clog2(ROUND_TIME+1)
//  COUNTDOWN_TICKS  3  ticks of countdown before each fight (>=1)
//  WINS_TO_MATCH    2  round wins that end the match (1..3)
//  MAX_ROUNDS       5  hard round limit (1..7); stops endless draws
// PORTS
//  clk                   in   1   system clock
//  rst                   in   1   synchronous reset, active-high
//  start                 in   1   begin a new match; honoured in IDLE and MATCH_END only
//  tick                  in   1   one-cycle game-time strobe from the external divider
//  left_player_input_in  in   6   raw left command (one-hot, GO_RIGHT..PUNCH)
//  right_player_input_in in   6   raw right command
//  left_player_health    in   2   left player present health
//  right_player_health   in   2   right player present health
//  pause                 in   1   freeze request (PAUSE_EN builds only)
//  player_rst_n          out  1   active-low reset to both player modules
//  action_valid          out  1   one-cycle strobe: the *_cmd outputs are this tick's action
//  left_player_cmd       out  6   registered, sanitised left command
//  right_player_cmd      out  6   registered, sanitised right command
//  state                 out  3   0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 ROUND_END, 4 MATCH_END
//  round_timer           out  TW  ticks remaining in the current round
//  round_num             out  3   current round number, 1-based
//  left_score            out  2   rounds won by left
//  right_score           out  2   rounds won by right
//  round_winner          out  2   00 none, 01 left, 10 right, 11 draw
//  match_winner          out  2   same encoding; valid while match_over=1
//  match_over            out  1   high in MATCH_END
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, any state, mid-round included):
//   - state=IDLE; all counters, scores and winners cleared to 0; action_valid=0; cmds=WAIT (6'b001000).
//   - player_rst_n=0 while rst is high.
//  IDLE / MATCH_END with start=1:
//   - next edge: state=COUNTDOWN, scores=0, round_num=1, winners=00, match_over=0.
//   - cd counter loaded with COUNTDOWN_TICKS; player_rst_n=0 for exactly that one cycle.
//  COUNTDOWN:
//   - each tick decrements cd.
//   - the tick with cd==1 moves to FIGHT at the next edge; round_timer=ROUND_TIME.
//  FIGHT:
//   - tick at cycle T: at T+1, cmds = sampled inputs, action_valid=1 for one cycle, round_timer-1.
//   - any input that is not exactly one-hot is replaced by WAIT.
//   - health checked every cycle; either health==0 -> ROUND_END next edge.
//   - round_winner: left 0 & right 0 -> 11; right 0 -> 01; left 0 -> 10.
//   - timer reaching 0 -> ROUND_END on the following edge; winner is the higher health, equal -> 11.
//   - KO and tick in the same cycle: KO wins; no action_valid and no timer decrement.
//   - score increments on the FIGHT->ROUND_END edge, none on a draw; saturates at WINS_TO_MATCH.
//  ROUND_END: action_valid=0, cmds=WAIT. On the next tick:
//   - if either score==WINS_TO_MATCH or round_num==MAX_ROUNDS -> MATCH_END, match_over=1.
//     match_winner = higher score; equal -> 11.
//   - else round_num+1 and COUNTDOWN; player_rst_n low one cycle; round_winner cleared to 00.
//  No other transitions. start is ignored outside IDLE and MATCH_END.
// CONFIGURATION
//  PAUSE_EN defined:
//   - while pause=1 in COUNTDOWN or FIGHT, ticks are ignored: no cd/timer decrement, no action_valid.
//   - state holds; KO detection stays active. Resume on pause=0 with the next tick.
//  PAUSE_EN undefined:
//   - pause port is still present but ignored; behaviour as above without freeze.
// TESTING (defaults)
//  1. rst held 3 cycles mid-FIGHT -> IDLE, scores 0, player_rst_n=0 during reset, cmds=WAIT.
//  2. start, 3 ticks -> COUNTDOWN for 3 ticks; FIGHT with round_timer=8; player_rst_n low exactly 1 cycle.
//  3. FIGHT, left_in=6'b000001 with tick -> next cycle left_cmd=000001, action_valid=1, timer=7;
//     left_in=6'b000011 -> left_cmd=001000.
//  4. Force right_health=0 -> ROUND_END, round_winner=01, left_score=1.
//     Repeat next round -> MATCH_END, match_winner=01, match_over=1.
//  5. 8 ticks with healths 3/3 -> timeout draw 11, no score change.
//     5 consecutive draws -> MATCH_END at round_num=5, match_winner=11.
//  6. Both health 0 and tick in the same cycle -> round_winner=11, no action_valid, timer unchanged.
//     PAUSE_EN: pause=1 for 4 ticks -> timer frozen.

Source files
------------

// File: rtl/round_controller.sv
// Match sequencer for the two-player fighter: countdown, fight, round-end and match-end phases.
// Optional build macro PAUSE_EN enables the pause freeze; without it the pause port is ignored.
module round_controller #(
  parameter int unsigned ROUND_TIME      = 8,
  parameter int unsigned COUNTDOWN_TICKS = 3,
  parameter int unsigned WINS_TO_MATCH   = 2,
  parameter int unsigned MAX_ROUNDS      = 5,
  localparam int unsigned TW = $clog2(ROUND_TIME + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          tick,
  input  logic [5:0]    left_player_input_in,
  input  logic [5:0]    right_player_input_in,
  input  logic [1:0]    left_player_health,
  input  logic [1:0]    right_player_health,
  input  logic          pause,
  output logic          player_rst_n,
  output logic          action_valid,
  output logic [5:0]    left_player_cmd,
  output logic [5:0]    right_player_cmd,
  output logic [2:0]    state,
  output logic [TW-1:0] round_timer,
  output logic [2:0]    round_num,
  output logic [1:0]    left_score,
  output logic [1:0]    right_score,
  output logic [1:0]    round_winner,
  output logic [1:0]    match_winner,
  output logic          match_over
);

  localparam int unsigned CW = $clog2(COUNTDOWN_TICKS + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] COUNTDOWN = 3'd1;
  localparam logic [2:0] FIGHT     = 3'd2;
  localparam logic [2:0] ROUND_END = 3'd3;
  localparam logic [2:0] MATCH_END = 3'd4;

  localparam logic [5:0] WAIT_CMD = 6'b001000;

  logic [CW-1:0] cd, cd_nxt;
  logic [2:0]    state_nxt;
  logic [TW-1:0] round_timer_nxt;
  logic [2:0]    round_num_nxt;
  logic [1:0]    left_score_nxt, right_score_nxt;
  logic [1:0]    round_winner_nxt, match_winner_nxt;
  logic          match_over_nxt, action_valid_nxt, player_rst_n_nxt;
  logic [5:0]    left_cmd_nxt, right_cmd_nxt;
  logic [1:0]    fight_win;
  logic          left_dead, right_dead, freeze, game_tick;

  // Freeze only suppresses ticks; KO detection keeps running underneath.
`ifdef PAUSE_EN
  assign freeze = pause && ((state == COUNTDOWN) || (state == FIGHT));
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign freeze       = 1'b0;
`endif

  assign game_tick  = tick && !freeze;
  assign left_dead  = (left_player_health == 2'd0);
  assign right_dead = (right_player_health == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cd               <= '0;
      round_timer      <= '0;
      round_num        <= '0;
      left_score       <= '0;
      right_score      <= '0;
      round_winner     <= 2'b00;
      match_winner     <= 2'b00;
      match_over       <= 1'b0;
      action_valid     <= 1'b0;
      left_player_cmd  <= WAIT_CMD;
      right_player_cmd <= WAIT_CMD;
      player_rst_n     <= 1'b0;
    end else begin
      state            <= state_nxt;
      cd               <= cd_nxt;
      round_timer      <= round_timer_nxt;
      round_num        <= round_num_nxt;
      left_score       <= left_score_nxt;
      right_score      <= right_score_nxt;
      round_winner     <= round_winner_nxt;
      match_winner     <= match_winner_nxt;
      match_over       <= match_over_nxt;
      action_valid     <= action_valid_nxt;
      left_player_cmd  <= left_cmd_nxt;
      right_player_cmd <= right_cmd_nxt;
      player_rst_n     <= player_rst_n_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cd_nxt           = cd;
    round_timer_nxt  = round_timer;
    round_num_nxt    = round_num;
    left_score_nxt   = left_score;
    right_score_nxt  = right_score;
    round_winner_nxt = round_winner;
    match_winner_nxt = match_winner;
    match_over_nxt   = match_over;
    action_valid_nxt = 1'b0;
    player_rst_n_nxt = 1'b1;
    left_cmd_nxt     = WAIT_CMD;
    right_cmd_nxt    = WAIT_CMD;
    fight_win        = 2'b00;

    case (state)
      IDLE, MATCH_END: begin
        if (start) begin
          state_nxt        = COUNTDOWN;
          cd_nxt           = CW'(COUNTDOWN_TICKS);
          round_num_nxt    = 3'd1;
          left_score_nxt   = 2'd0;
          right_score_nxt  = 2'd0;
          round_winner_nxt = 2'b00;
          match_winner_nxt = 2'b00;
          match_over_nxt   = 1'b0;
          player_rst_n_nxt = 1'b0;
        end
      end

      COUNTDOWN: begin
        if (game_tick) begin
          cd_nxt = cd - CW'(1);
          if (cd == CW'(1)) begin
            state_nxt       = FIGHT;
            round_timer_nxt = TW'(ROUND_TIME);
          end
        end
      end

      FIGHT: begin
        if (left_dead || right_dead) begin
          state_nxt = ROUND_END;
          fight_win = {left_dead, right_dead};
        end else if (round_timer == '0) begin
          state_nxt = ROUND_END;
          if (left_player_health > right_player_health)      fight_win = 2'b01;
          else if (right_player_health > left_player_health) fight_win = 2'b10;
          else                                               fight_win = 2'b11;
        end else if (game_tick) begin
          action_valid_nxt = 1'b1;
          round_timer_nxt  = round_timer - TW'(1);
          left_cmd_nxt     = $onehot(left_player_input_in)  ? left_player_input_in  : WAIT_CMD;
          right_cmd_nxt    = $onehot(right_player_input_in) ? right_player_input_in : WAIT_CMD;
        end
        // Scores move only on the FIGHT->ROUND_END edge and saturate at the match target.
        if (state_nxt == ROUND_END) begin
          round_winner_nxt = fight_win;
          if (fight_win == 2'b01 && left_score != 2'(WINS_TO_MATCH))
            left_score_nxt = left_score + 2'd1;
          if (fight_win == 2'b10 && right_score != 2'(WINS_TO_MATCH))
            right_score_nxt = right_score + 2'd1;
        end
      end

      ROUND_END: begin
        if (tick) begin
          if (left_score == 2'(WINS_TO_MATCH) || right_score == 2'(WINS_TO_MATCH) ||
              round_num == 3'(MAX_ROUNDS)) begin
            state_nxt      = MATCH_END;
            match_over_nxt = 1'b1;
            if (left_score > right_score)      match_winner_nxt = 2'b01;
            else if (right_score > left_score) match_winner_nxt = 2'b10;
            else                               match_winner_nxt = 2'b11;
          end else begin
            state_nxt        = COUNTDOWN;
            cd_nxt           = CW'(COUNTDOWN_TICKS);
            round_num_nxt    = round_num + 3'd1;
            round_winner_nxt = 2'b00;
            player_rst_n_nxt = 1'b0;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_round_controller.sv
// Directed self-checking bench for round_controller (default parameters).
// Expected values are hand-derived; define PAUSE_EN on both files to exercise the freeze build.
module tb_round_controller;

  logic       clk = 1'b0;
  logic       rst, start, tick, pause;
  logic [5:0] left_in, right_in;
  logic [1:0] left_health, right_health;
  logic       player_rst_n, action_valid;
  logic [5:0] left_cmd, right_cmd;
  logic [2:0] state, round_num;
  logic [3:0] round_timer;
  logic [1:0] left_score, right_score, round_winner, match_winner;
  logic       match_over;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] WAIT_CMD = 6'b001000;

  always #5 clk = ~clk;

  round_controller dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick),
    .left_player_input_in(left_in), .right_player_input_in(right_in),
    .left_player_health(left_health), .right_player_health(right_health),
    .pause(pause), .player_rst_n(player_rst_n), .action_valid(action_valid),
    .left_player_cmd(left_cmd), .right_player_cmd(right_cmd), .state(state),
    .round_timer(round_timer), .round_num(round_num), .left_score(left_score),
    .right_score(right_score), .round_winner(round_winner),
    .match_winner(match_winner), .match_over(match_over)
  );

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_countdown();
    for (int i = 0; i < 3; i++) pulse_tick();
  endtask

  task automatic test_power_on();
    checks++;
    if (state !== 3'd0 || player_rst_n !== 1'b1 || left_cmd !== WAIT_CMD || action_valid !== 1'b0) begin
      errors++;
      $display("FAIL power_on: state=%0d rst_n=%b cmd=%b av=%b, want 0 1 001000 0",
               state, player_rst_n, left_cmd, action_valid);
    end
  endtask

  task automatic test_countdown();
    pulse_start();
    checks++;
    if (state !== 3'd1 || player_rst_n !== 1'b0 || round_num !== 3'd1) begin
      errors++;
      $display("FAIL start_edge: state=%0d rst_n=%b round=%0d, want 1 0 1", state, player_rst_n, round_num);
    end
    step();
    checks++;
    if (player_rst_n !== 1'b1 || state !== 3'd1) begin
      errors++;
      $display("FAIL player_rst_pulse: rst_n=%b state=%0d, want 1 1", player_rst_n, state);
    end
    for (int i = 0; i < 2; i++) begin
      pulse_tick();
      checks++;
      if (state !== 3'd1) begin
        errors++;
        $display("FAIL countdown_hold%0d: state=%0d want 1", i, state);
      end
    end
    pulse_tick();
    checks++;
    if (state !== 3'd2 || round_timer !== 4'd8) begin
      errors++;
      $display("FAIL enter_fight: state=%0d timer=%0d, want 2 8", state, round_timer);
    end
  endtask

  task automatic test_action();
    left_in = 6'b000001; right_in = 6'b000100;
    pulse_tick();
    checks++;
    if (left_cmd !== 6'b000001 || right_cmd !== 6'b000100 || action_valid !== 1'b1 || round_timer !== 4'd7) begin
      errors++;
      $display("FAIL action: l=%b r=%b av=%b timer=%0d, want 000001 000100 1 7",
               left_cmd, right_cmd, action_valid, round_timer);
    end
    step();
    checks++;
    if (action_valid !== 1'b0 || round_timer !== 4'd7) begin
      errors++;
      $display("FAIL action_one_cycle: av=%b timer=%0d, want 0 7", action_valid, round_timer);
    end
    left_in = 6'b000011; right_in = 6'b000000;
    pulse_tick();
    checks++;
    if (left_cmd !== WAIT_CMD || right_cmd !== WAIT_CMD || action_valid !== 1'b1 || round_timer !== 4'd6) begin
      errors++;
      $display("FAIL sanitise: l=%b r=%b av=%b timer=%0d, want 001000 001000 1 6",
               left_cmd, right_cmd, action_valid, round_timer);
    end
    left_in = WAIT_CMD; right_in = WAIT_CMD;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if (player_rst_n !== 1'b0 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_first: rst_n=%b state=%0d, want 0 0", player_rst_n, state);
    end
    step();
    step();
    checks++;
    if (state !== 3'd0 || left_score !== 2'd0 || round_timer !== 4'd0 || round_num !== 3'd0 ||
        left_cmd !== WAIT_CMD || right_cmd !== WAIT_CMD || action_valid !== 1'b0 || player_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: state=%0d ls=%0d timer=%0d round=%0d l=%b r=%b av=%b rst_n=%b",
               state, left_score, round_timer, round_num, left_cmd, right_cmd, action_valid, player_rst_n);
    end
    rst = 1'b0;
    step();
    checks++;
    if (player_rst_n !== 1'b1 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: rst_n=%b state=%0d, want 1 0", player_rst_n, state);
    end
  endtask

  task automatic test_ko_match();
    pulse_start();
    run_countdown();
    right_health = 2'd0;
    step();
    right_health = 2'd3;
    checks++;
    if (state !== 3'd3 || round_winner !== 2'b01 || left_score !== 2'd1 || right_score !== 2'd0) begin
      errors++;
      $display("FAIL ko_round1: state=%0d rw=%b ls=%0d rs=%0d, want 3 01 1 0",
               state, round_winner, left_score, right_score);
    end
    pulse_tick();
    checks++;
    if (state !== 3'd1 || round_num !== 3'd2 || round_winner !== 2'b00 || player_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL next_round: state=%0d round=%0d rw=%b rst_n=%b, want 1 2 00 0",
               state, round_num, round_winner, player_rst_n);
    end
    run_countdown();
    right_health = 2'd0;
    step();
    right_health = 2'd3;
    checks++;
    if (state !== 3'd3 || left_score !== 2'd2) begin
      errors++;
      $display("FAIL ko_round2: state=%0d ls=%0d, want 3 2", state, left_score);
    end
    pulse_tick();
    checks++;
    if (state !== 3'd4 || match_over !== 1'b1 || match_winner !== 2'b01) begin
      errors++;
      $display("FAIL ko_match: state=%0d mo=%b mw=%b, want 4 1 01", state, match_over, match_winner);
    end
  endtask

  task automatic test_draw_match();
    pulse_start();
    checks++;
    if (state !== 3'd1 || match_over !== 1'b0 || left_score !== 2'd0 || round_num !== 3'd1 || match_winner !== 2'b00) begin
      errors++;
      $display("FAIL restart: state=%0d mo=%b ls=%0d round=%0d mw=%b, want 1 0 0 1 00",
               state, match_over, left_score, round_num, match_winner);
    end
    for (int r = 1; r <= 5; r++) begin
      run_countdown();
      for (int t = 0; t < 8; t++) pulse_tick();
      checks++;
      if (state !== 3'd2 || round_timer !== 4'd0) begin
        errors++;
        $display("FAIL timer_zero r%0d: state=%0d timer=%0d, want 2 0", r, state, round_timer);
      end
      step();
      checks++;
      if (state !== 3'd3 || round_winner !== 2'b11 || left_score !== 2'd0 || right_score !== 2'd0) begin
        errors++;
        $display("FAIL draw r%0d: state=%0d rw=%b ls=%0d rs=%0d, want 3 11 0 0",
                 r, state, round_winner, left_score, right_score);
      end
      pulse_tick();
      checks++;
      if (r < 5 && (state !== 3'd1 || round_num !== 3'(r + 1))) begin
        errors++;
        $display("FAIL draw_next r%0d: state=%0d round=%0d, want 1 %0d", r, state, round_num, r + 1);
      end else if (r == 5 && (state !== 3'd4 || match_winner !== 2'b11 || round_num !== 3'd5)) begin
        errors++;
        $display("FAIL draw_match: state=%0d mw=%b round=%0d, want 4 11 5", state, match_winner, round_num);
      end
    end
  endtask

  task automatic test_ko_tick_same();
    pulse_start();
    run_countdown();
    left_in = 6'b100000;
    pulse_tick();
    left_in = WAIT_CMD;
    left_health = 2'd0; right_health = 2'd0; tick = 1'b1;
    step();
    tick = 1'b0; left_health = 2'd3; right_health = 2'd3;
    checks++;
    if (state !== 3'd3 || round_winner !== 2'b11 || action_valid !== 1'b0 || round_timer !== 4'd7 ||
        left_score !== 2'd0 || right_score !== 2'd0) begin
      errors++;
      $display("FAIL ko_with_tick: state=%0d rw=%b av=%b timer=%0d ls=%0d rs=%0d, want 3 11 0 7 0 0",
               state, round_winner, action_valid, round_timer, left_score, right_score);
    end
  endtask

  task automatic test_pause();
    logic [3:0] want_frozen, want_after;
    logic       want_av;
`ifdef PAUSE_EN
    want_frozen = 4'd8; want_after = 4'd7; want_av = 1'b0;
`else
    want_frozen = 4'd4; want_after = 4'd3; want_av = 1'b1;
`endif
    pulse_tick();
    run_countdown();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) pulse_tick();
    checks++;
    if (round_timer !== want_frozen || action_valid !== want_av || state !== 3'd2) begin
      errors++;
      $display("FAIL pause_hold: timer=%0d av=%b state=%0d, want %0d %b 2",
               round_timer, action_valid, state, want_frozen, want_av);
    end
    pause = 1'b0;
    pulse_tick();
    checks++;
    if (round_timer !== want_after || action_valid !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume: timer=%0d av=%b, want %0d 1", round_timer, action_valid, want_after);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; tick = 1'b0; pause = 1'b0;
    left_in = WAIT_CMD; right_in = WAIT_CMD;
    left_health = 2'd3; right_health = 2'd3;
    step();
    step();
    rst = 1'b0;
    step();
    test_power_on();
    test_countdown();
    test_action();
    test_reset();
    test_ko_match();
    test_draw_match();
    test_ko_tick_same();
    test_pause();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
